if_id_queue: RTL

Parametrised instruction buffer between if_stage and id_stage. It replaces the single id_ready backpressure wire with a valid/ready handshake on both sides. It decouples fetch from decode stalls by holding up to DEPTH instruction/PC pairs, and supports a single-cycle flush for branch/exception redirects. First-word-fall-through: the head entry is presented to decode directly from storage.

---
 rtl/if_id_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Instruction buffer between if_stage and id_stage.
// FIFO of instr/PC pairs, valid/ready on both sides, single-cycle flush.
module if_id_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_if_valid,
    input  logic [INSTR_W-1:0]         i_if_instr,
    input  logic [PC_W-1:0]            i_if_pc,
    output logic                       o_if_ready,
    output logic                       o_id_valid,
    output logic [INSTR_W-1:0]         o_id_instr,
    output logic [PC_W-1:0]            o_id_pc,
    input  logic                       i_id_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Ready depends on registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign o_if_ready = ~full;
    assign o_id_valid = ~empty & ~i_flush;
    assign o_count    = count_q;

    assign push = i_if_valid & o_if_ready & ~i_flush;
    assign pop  = o_id_valid & i_id_ready;

    always_comb begin
        o_id_instr = '0;
        o_id_pc    = '0;
        if (!empty) begin
            o_id_instr = instr_mem[rptr_q];
            o_id_pc    = pc_mem[rptr_q];
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wptr_q] <= i_if_instr;
            pc_mem[wptr_q]    <= i_if_pc;
        end
    end

endmodule
